// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type and memory arbiter state encoding
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DATA  = 3'd1,
      VLANE = 3'd2,
      FETCH = 3'd3,
      HALT  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/vlane_sel.sv
// rtl/vlane_sel.sv - vector lane stepping: current lane enable, last-lane flag, next lane index
module vlane_sel #(
   parameter int THREADS = 4,
   parameter int LW      = 2
) (
   input  logic [THREADS-1:0] vmask_i,
   input  logic [LW-1:0]      lane_i,
   output logic               lane_active_o,
   output logic               lane_last_o,
   output logic [LW-1:0]      lane_next_o
);

   // Lanes advance one per step so masked-off lanes still cost exactly one cycle
   always_comb begin
      lane_active_o = vmask_i[lane_i];
      lane_last_o   = (lane_i == LW'(THREADS - 1));
      lane_next_o   = lane_i + 1'b1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch, scalar and vector data (option: MEM_ARBITER_COALESCE_EN)
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     instReq,
   input  word_t                    iaddr,
   output logic                     iHit,
   output word_t                    iload,
   input  logic                     readReq,
   input  logic                     writeReq,
   input  logic                     isVector,
   input  word_t                    sdaddr,
   input  word_t                    sdstore,
   input  word_t [THREADS-1:0]      vdaddr,
   input  word_t [THREADS-1:0]      vdstore,
   input  logic  [THREADS-1:0]      vmask,
   input  logic                     dhalt,
   output logic                     dHit,
   output word_t                    sdload,
   output word_t [THREADS-1:0]      vdload,
   output logic                     ramREN,
   output logic                     ramWEN,
   output word_t                    ramaddr,
   output word_t                    ramstore,
   input  logic                     ramReady,
   input  word_t                    ramload
);

   localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;

   arb_state_t          state_q, state_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic                done_q, done_d;
   logic                ihit_q, ihit_d;
   logic                dhit_q, dhit_d;
   word_t               iload_q, iload_d;
   word_t               sdload_q, sdload_d;
   word_t [THREADS-1:0] vdload_q, vdload_d;

   logic                lane_active;
   logic                lane_last;
   logic [LW-1:0]       lane_next;
   logic                lane_done;
   logic                coalesce_hit;
   word_t               coalesce_data;

   vlane_sel #(
      .THREADS (THREADS),
      .LW      (LW)
   ) u_vlane_sel (
      .vmask_i       (vmask),
      .lane_i        (lane_q),
      .lane_active_o (lane_active),
      .lane_last_o   (lane_last),
      .lane_next_o   (lane_next)
   );

   // A lane finishes when skipped, coalesced, or when memory acknowledges it
   assign lane_done = lane_active ? (coalesce_hit | ramReady) : 1'b1;

`ifdef MEM_ARBITER_COALESCE_EN
   logic  last_valid_q;
   word_t last_addr_q;
   word_t last_data_q;

   // Track the most recently serviced active lane of the current vector access
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_valid_q <= 1'b0;
         last_addr_q  <= '0;
         last_data_q  <= '0;
      end else if (state_q != VLANE) begin
         last_valid_q <= 1'b0;
      end else if (lane_active && lane_done) begin
         last_valid_q <= 1'b1;
         last_addr_q  <= vdaddr[lane_q];
         last_data_q  <= coalesce_hit ? last_data_q : ramload;
      end
   end

   assign coalesce_hit  = (state_q == VLANE) & readReq & lane_active & last_valid_q
                        & (vdaddr[lane_q] == last_addr_q);
   assign coalesce_data = last_data_q;
`else
   assign coalesce_hit  = 1'b0;
   assign coalesce_data = '0;
`endif

   // State and result registers; reset abandons any access in flight
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         done_q   <= 1'b0;
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         iload_q  <= '0;
         sdload_q <= '0;
         vdload_q <= '0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         done_q   <= done_d;
         ihit_q   <= ihit_d;
         dhit_q   <= dhit_d;
         iload_q  <= iload_d;
         sdload_q <= sdload_d;
         vdload_q <= vdload_d;
      end
   end

   // Next-state and memory port drive; strobes depend only on state and held requests
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      done_d   = done_q;
      ihit_d   = 1'b0;
      dhit_d   = 1'b0;
      iload_d  = iload_q;
      sdload_d = sdload_q;
      vdload_d = vdload_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;

      case (state_q)
         IDLE: begin
            if (dhalt) begin
               state_d = HALT;
            end else if ((readReq | writeReq) & !done_q) begin
               lane_d  = '0;
               state_d = isVector ? VLANE : DATA;
            end else if (instReq) begin
               state_d = FETCH;
            end
         end

         DATA: begin
            ramREN   = readReq;
            ramWEN   = writeReq & !readReq;
            ramaddr  = sdaddr;
            ramstore = sdstore;
            if (ramReady) begin
               sdload_d = ramload;
               dhit_d   = 1'b1;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end

         VLANE: begin
            if (lane_active && !coalesce_hit) begin
               ramREN   = readReq;
               ramWEN   = writeReq & !readReq;
               ramaddr  = vdaddr[lane_q];
               ramstore = vdstore[lane_q];
            end
            if (lane_active && coalesce_hit) begin
               vdload_d[lane_q] = coalesce_data;
            end else if (lane_active && ramReady && readReq) begin
               vdload_d[lane_q] = ramload;
            end
            if (lane_done) begin
               if (lane_last) begin
                  lane_d  = '0;
                  dhit_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  lane_d  = lane_next;
               end
            end
         end

         FETCH: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ramReady) begin
               iload_d = ramload;
               ihit_d  = 1'b1;
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end

         HALT: begin
            state_d = HALT;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign iHit   = ihit_q;
   assign dHit   = dhit_q;
   assign iload  = iload_q;
   assign sdload = sdload_q;
   assign vdload = vdload_q;

endmodule
